neuron_core_sweep: RTL and testbench

- Parametrised successor to the fixed 4-lane post-neuron core.
- A single accepted event makes the block sweep every post-neuron word: it fetches synaptic weights, updates LANES integrate-and-fire neurons per word, and writes the state back.
- New over the previous generation: configurable lane count and widths, signed saturating arithmetic, leak on time step, soft reset, an event handshake, and a program read/write port.
- Sits between the event controller / SPI config and the synapse SRAM.

---
 rtl/neuron_core_sweep.sv | 150 +++++++++++++++
 tb/tb_neuron_core_sweep.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_core_sweep.sv
// neuron_core_sweep: event-driven sweep updating LANES integrate-and-fire neurons per state word
module neuron_core_sweep #(
    parameter int N_POST = 256,
    parameter int LANES  = 4,
    parameter int MEM_W  = 12,
    parameter int W_W    = 8,
    parameter int CNT_W  = 7,
    localparam int WORDS = N_POST / LANES,
    localparam int WAW   = $clog2(WORDS),
    localparam int NAW   = $clog2(N_POST),
    localparam int ST_W  = 1 + CNT_W + MEM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  evt_valid,
    output logic                  evt_ready,
    input  logic [1:0]            evt_type,
    output logic                  syn_ren,
    output logic [WAW-1:0]        syn_addr,
    input  logic [LANES*W_W-1:0]  syn_rdata,
    input  logic [MEM_W-1:0]      thr,
    input  logic [MEM_W-1:0]      leak,
    input  logic                  prog_we,
    input  logic                  prog_re,
    input  logic [NAW-1:0]        prog_addr,
    input  logic [ST_W-1:0]       prog_wdata,
    output logic [ST_W-1:0]       prog_rdata,
    output logic                  prog_rvalid,
    output logic                  spike_valid,
    output logic [WAW-1:0]        spike_word,
    output logic [LANES-1:0]      spike_mask,
    output logic                  busy
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic signed [MEM_W+1:0] MEM_MAX = (MEM_W+2)'(2**(MEM_W-1) - 1);
    localparam logic signed [MEM_W+1:0] MEM_MIN = (MEM_W+2)'(-(2**(MEM_W-1)));

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t                  state;
    logic [WAW-1:0]          addr;
    logic                    drain_cnt;
    logic [1:0]              typ_q;
    logic [MEM_W-1:0]        thr_q;
    logic [MEM_W-1:0]        leak_q;
    logic                    s1_v;
    logic [WAW-1:0]          s1_addr;
    logic [ST_W-1:0]         ram [WORDS][LANES];
    logic [ST_W-1:0]         rd_q [LANES];
    logic [ST_W-1:0]         nxt [LANES];
    logic [LANES-1:0]        fire;
    logic                    accept;
    logic                    prog_ok;
    logic [WAW-1:0]          p_word;
    logic [LW-1:0]           p_lane;

    assign evt_ready = state == IDLE && !prog_we && !prog_re;
    assign busy      = state != IDLE;
    assign syn_ren   = state == SWEEP;
    assign syn_addr  = addr;
    assign accept    = evt_valid && evt_ready;
    assign prog_ok   = state == IDLE && rst_n;
    assign p_word    = WAW'(prog_addr / NAW'(LANES));
    assign p_lane    = LW'(prog_addr % NAW'(LANES));

    function automatic logic [MEM_W-1:0] sat(input logic signed [MEM_W+1:0] v);
        return v > MEM_MAX ? MEM_MAX[MEM_W-1:0] : v < MEM_MIN ? MEM_MIN[MEM_W-1:0] : v[MEM_W-1:0];
    endfunction

    // returns {fire, new_state}; disabled lanes pass through untouched
    function automatic logic [ST_W:0] upd(input logic [ST_W-1:0] st, input logic [W_W-1:0] w);
        logic en, f;
        logic [CNT_W-1:0] cnt, nc;
        logic [MEM_W-1:0] sm, nm;
        logic signed [MEM_W+1:0] m, t, l, s, lk;
        en  = st[ST_W-1];
        cnt = st[MEM_W +: CNT_W];
        m   = {{2{st[MEM_W-1]}}, st[MEM_W-1:0]};
        t   = {{2{thr_q[MEM_W-1]}}, thr_q};
        l   = {2'b00, leak_q};
        sm  = sat(m + {{(MEM_W+2-W_W){w[W_W-1]}}, w});
        s   = {{2{sm[MEM_W-1]}}, sm};
        f   = en && typ_q == 2'b00 && s >= t;
        lk  = m > l ? m - l : m < -l ? m + l : '0;
        nm  = typ_q == 2'b10 ? '0 : typ_q == 2'b01 ? lk[MEM_W-1:0] : f ? sat(s - t) : sm;
        nc  = typ_q == 2'b10 ? '0 : f && cnt != '1 ? cnt + CNT_W'(1) : cnt;
        return en ? {f, en, nc, nm} : {1'b0, st};
    endfunction

    always_comb begin
        fire = '0;
        for (int i = 0; i < LANES; i++) begin
            {fire[i], nxt[i]} = upd(rd_q[i], syn_rdata[i*W_W +: W_W]);
        end
    end

    // a reset cycle suppresses the in-flight write-back, so aborted words keep their old state
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (syn_ren) rd_q[i] <= ram[addr][i];
            if (rst_n && s1_v) ram[s1_addr][i] <= nxt[i];
        end
        if (prog_ok && prog_we) ram[p_word][p_lane] <= prog_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            drain_cnt   <= 1'b0;
            s1_v        <= 1'b0;
            s1_addr     <= '0;
            spike_valid <= 1'b0;
            spike_word  <= '0;
            spike_mask  <= '0;
            prog_rvalid <= 1'b0;
            prog_rdata  <= '0;
        end else begin
            prog_rvalid <= prog_ok && prog_re && !prog_we;
            if (prog_ok && prog_re && !prog_we) prog_rdata <= ram[p_word][p_lane];
            if (accept) begin
                typ_q  <= evt_type;
                thr_q  <= thr;
                leak_q <= leak;
            end
            s1_v        <= syn_ren;
            s1_addr     <= addr;
            spike_valid <= s1_v && typ_q == 2'b00;
            if (s1_v && typ_q == 2'b00) begin
                spike_word <= s1_addr;
                spike_mask <= fire;
            end
            case (state)
                IDLE: begin
                    addr <= '0;
                    if (accept && evt_type != 2'b11) state <= SWEEP;
                end
                SWEEP: begin
                    addr  <= addr == WAW'(WORDS - 1) ? '0 : addr + WAW'(1);
                    state <= addr == WAW'(WORDS - 1) ? DRAIN : SWEEP;
                end
                DRAIN: begin
                    drain_cnt <= !drain_cnt;
                    if (drain_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_core_sweep.sv
// tb_neuron_core_sweep: directed vectors against hand-computed neuron states and spike masks
module tb_neuron_core_sweep;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [1:0]  evt_type = 2'b00;
    logic        syn_ren;
    logic [5:0]  syn_addr;
    logic [31:0] syn_rdata = '0;
    logic [11:0] thr = '0;
    logic [11:0] leak = '0;
    logic        prog_we = 1'b0;
    logic        prog_re = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [19:0] prog_wdata = '0;
    logic [19:0] prog_rdata;
    logic        prog_rvalid;
    logic        spike_valid;
    logic [5:0]  spike_word;
    logic [3:0]  spike_mask;
    logic        busy;

    logic [31:0] wmem [64];
    logic [3:0]  mask_seen [64];
    int n_vec = 0;
    int n_err = 0;
    int spikes, lowcnt, nz;

    neuron_core_sweep dut (
        .clk(clk), .rst_n(rst_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .syn_ren(syn_ren), .syn_addr(syn_addr), .syn_rdata(syn_rdata),
        .thr(thr), .leak(leak), .prog_we(prog_we), .prog_re(prog_re), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_rdata(prog_rdata), .prog_rvalid(prog_rvalid),
        .spike_valid(spike_valid), .spike_word(spike_word), .spike_mask(spike_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    // synapse SRAM: one-cycle read latency
    always @(posedge clk) if (syn_ren) syn_rdata <= wmem[syn_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prog_wr(input int a, input logic [19:0] d);
        prog_we = 1'b1;
        prog_addr = 8'(a);
        prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [19:0] exp);
        prog_re = 1'b1;
        prog_addr = 8'(a);
        tick();
        prog_re = 1'b0;
        chk(tag, {11'd0, prog_rvalid, prog_rdata}, {12'd1, exp});
    endtask

    task automatic wait_sweep();
        spikes = 0;
        lowcnt = 0;
        nz = 0;
        for (int i = 0; i < 64; i++) mask_seen[i] = '0;
        while (!evt_ready && lowcnt < 200) begin
            if (spike_valid) begin
                spikes++;
                mask_seen[spike_word] = spike_mask;
                if (spike_mask != 4'd0) nz++;
            end
            lowcnt++;
            tick();
        end
    endtask

    task automatic evt(input logic [1:0] ty, input logic [11:0] th, input logic [11:0] lk);
        evt_valid = 1'b1;
        evt_type = ty;
        thr = th;
        leak = lk;
        tick();
        evt_valid = 1'b0;
        wait_sweep();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) wmem[i] = '0;
        repeat (2) tick();
        chk("reset_ctl", {27'd0, evt_ready, busy, syn_ren, spike_valid, prog_rvalid}, 32'b10000);
        chk("reset_data", {16'd0, syn_addr, spike_word, spike_mask}, 32'd0);
        chk("reset_rdata", {12'd0, prog_rdata}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) prog_wr(i, 20'd0);

        // single firing neuron; 0x7F0+0x20 saturates to 0x7FF before THR is subtracted
        prog_wr(5, {1'b1, 7'd0, 12'h7F0});
        wmem[1] = 32'h0000_2000;
        evt(2'b00, 12'h100, 12'h000);
        chk("t1_spikes", 32'(spikes), 32'd64);
        chk("t1_ready_low", 32'(lowcnt), 32'd66);
        chk("t1_mask_w1", 32'(mask_seen[1]), 32'b0010);
        chk("t1_nonzero", 32'(nz), 32'd1);
        rd_chk("t1_n5", 5, {1'b1, 7'd1, 12'h6FF});

        // saturated add still fires; spike counter holds at its maximum
        wmem[1] = '0;
        prog_wr(8, {1'b1, 7'h7F, 12'h7FF});
        wmem[2] = 32'h0000_007F;
        evt(2'b00, 12'h7FF, 12'h000);
        chk("t2_mask_w2", 32'(mask_seen[2]), 32'b0001);
        chk("t2_nonzero", 32'(nz), 32'd1);
        rd_chk("t2_n8", 8, {1'b1, 7'h7F, 12'h000});
        rd_chk("t2_n5", 5, {1'b1, 7'd1, 12'h6FF});

        // leak toward zero without crossing
        wmem[2] = '0;
        prog_wr(12, {1'b1, 7'd0, 12'h005});
        prog_wr(13, {1'b1, 7'd0, 12'hFFB});
        prog_wr(14, {1'b1, 7'd0, 12'h002});
        prog_wr(15, {1'b1, 7'd0, 12'h800});
        evt(2'b01, 12'h000, 12'h003);
        chk("t3_spikes", 32'(spikes), 32'd0);
        chk("t3_ready_low", 32'(lowcnt), 32'd66);
        rd_chk("t3_n12", 12, {1'b1, 7'd0, 12'h002});
        rd_chk("t3_n13", 13, {1'b1, 7'd0, 12'hFFE});
        rd_chk("t3_n14", 14, {1'b1, 7'd0, 12'h000});
        rd_chk("t3_n15", 15, {1'b1, 7'd0, 12'h803});
        rd_chk("t3_n5", 5, {1'b1, 7'd1, 12'h6FC});

        // disabled lane 16 next to enabled lane 17
        prog_wr(16, {1'b0, 7'd3, 12'h500});
        prog_wr(17, {1'b1, 7'd2, 12'h010});
        wmem[4] = 32'h0000_7F7F;
        evt(2'b00, 12'h050, 12'h000);
        chk("t4_mask_w4", 32'(mask_seen[4]), 32'b0010);
        chk("t4_mask_w1", 32'(mask_seen[1]), 32'b0010);
        chk("t4_nonzero", 32'(nz), 32'd2);
        rd_chk("t4_n16_spk", 16, {1'b0, 7'd3, 12'h500});
        rd_chk("t4_n17_spk", 17, {1'b1, 7'd3, 12'h03F});
        rd_chk("t4_n5_spk", 5, {1'b1, 7'd2, 12'h6AC});
        evt(2'b01, 12'h000, 12'h010);
        rd_chk("t4_n16_leak", 16, {1'b0, 7'd3, 12'h500});
        rd_chk("t4_n17_leak", 17, {1'b1, 7'd3, 12'h02F});
        wmem[4] = '0;
        evt(2'b10, 12'h000, 12'h000);
        chk("t4_tref_spikes", 32'(spikes), 32'd0);
        rd_chk("t4_n16_tref", 16, {1'b0, 7'd3, 12'h500});
        rd_chk("t4_n17_tref", 17, {1'b1, 7'd0, 12'h000});
        rd_chk("t4_n8_tref", 8, {1'b1, 7'd0, 12'h000});
        evt(2'b11, 12'h000, 12'h000);
        chk("t4_ignored_low", 32'(lowcnt), 32'd0);

        // programming beats a simultaneous event, and is ignored while busy
        prog_we = 1'b1;
        prog_addr = 8'd20;
        prog_wdata = {1'b1, 7'd0, 12'h100};
        evt_valid = 1'b1;
        evt_type = 2'b00;
        thr = 12'h7FF;
        leak = 12'h000;
        #1;
        chk("t5_ready_blocked", {31'd0, evt_ready}, 32'd0);
        tick();
        prog_we = 1'b0;
        #1;
        chk("t5_not_accepted", {30'd0, busy, evt_ready}, 32'b01);
        tick();
        evt_valid = 1'b0;
        chk("t5_accepted", {31'd0, busy}, 32'd1);
        prog_we = 1'b1;
        prog_addr = 8'd21;
        prog_wdata = {1'b1, 7'd0, 12'h123};
        tick();
        prog_we = 1'b0;
        wait_sweep();
        rd_chk("t5_n20", 20, {1'b1, 7'd0, 12'h100});
        rd_chk("t5_n21", 21, {1'b0, 7'd0, 12'h000});

        // reset during sweep cycle 10: words 0..8 written, 9.. untouched
        for (int k = 0; k < 64; k++) begin
            prog_wr(4 * k, {1'b1, 7'd0, 12'h000});
            wmem[k] = 32'h0000_0001;
        end
        evt_valid = 1'b1;
        evt_type = 2'b00;
        thr = 12'h7FF;
        tick();
        evt_valid = 1'b0;
        repeat (10) tick();
        chk("t6_pre_abort", {25'd0, busy, syn_addr}, {25'd0, 1'b1, 6'd10});
        rst_n = 1'b0;
        tick();
        chk("t6_abort_ctl", {27'd0, evt_ready, busy, syn_ren, spike_valid, prog_rvalid}, 32'b10000);
        chk("t6_abort_data", {16'd0, syn_addr, spike_word, spike_mask}, 32'd0);
        chk("t6_abort_rdata", {12'd0, prog_rdata}, 32'd0);
        rst_n = 1'b1;
        spikes = 0;
        repeat (3) begin
            tick();
            if (spike_valid) spikes++;
        end
        chk("t6_quiet", 32'(spikes), 32'd0);
        rd_chk("t6_w0", 0, {1'b1, 7'd0, 12'h001});
        rd_chk("t6_w8", 32, {1'b1, 7'd0, 12'h001});
        rd_chk("t6_w9", 36, {1'b1, 7'd0, 12'h000});
        rd_chk("t6_w63", 252, {1'b1, 7'd0, 12'h000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
